fetch_prefetch_buffer: RTL

FETCH_PREFETCH_BUFFER -- requirements
Module: fetch_prefetch_buffer

---
 rtl/fetch_prefetch_buffer.sv | 114 +++++++++++
 1 files changed

// File: rtl/fetch_prefetch_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fetch_prefetch_buffer
//  Purpose  : Instruction prefetch queue between instruction memory and IF/ID,
//             with credit-based fetch issue and flush-on-redirect.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_prefetch_buffer #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    input  logic                     stall,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic [XLEN-1:0]          imem_rdata,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]   c_depth = CW'(DEPTH);
    localparam logic [XLEN-1:0] c_step  = XLEN'(4);

    logic [XLEN-1:0] r_fetch_pc;
    logic            r_inflight;
    logic [XLEN-1:0] r_inflight_pc;
    logic [XLEN-1:0] r_pc_q    [DEPTH];
    logic [XLEN-1:0] r_instr_q [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_valid;
    logic            w_credit;
    logic            w_req;
    logic            w_push;
    logic            w_pop;
    logic            w_unused;

    // Low address bits of a redirect target are architecturally ignored.
    assign w_unused = ^redirect_pc[1:0];

    // A slot is reserved for every outstanding read, so a push can never
    // land on a full queue.
    assign w_valid  = (r_count != '0);
    assign w_credit = ((r_count + CW'(r_inflight)) < c_depth);
    assign w_req    = !reset && !redirect_valid && w_credit;
    assign w_push   = r_inflight && !redirect_valid;
    assign w_pop    = w_valid && !stall && !redirect_valid;

    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc;
    assign out_valid = w_valid;
    assign out_pc    = w_valid ? r_pc_q[r_rptr]    : '0;
    assign out_instr = w_valid ? r_instr_q[r_rptr] : '0;
    assign occupancy = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            if (w_req) begin
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + c_step;
            end else if (w_push) begin
                r_inflight <= 1'b0;
            end

            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue payload carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_q[r_wptr]    <= r_inflight_pc;
            r_instr_q[r_wptr] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire
